fifo_sync_flags: RTL and testbench

Parametrised single-clock FIFO. Successor to the basic synchronous FIFO.
- Adds registered accurate flags, occupancy count and programmable almost-full/almost-empty thresholds.
- Adds sticky overflow/underflow error flags, non-power-of-2 depth and correct simultaneous read/write at full and empty.
- Sits between a producer and a consumer in the same clock domain, e.g. a packet/sample buffer in front of a stalling sink.

---
 rtl/fifo_sync_flags_if.sv | 32 +++
 rtl/fifo_sync_flags.sv | 84 ++++++++
 tb/tb_fifo_sync_flags.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_flags_if.sv
// Producer/consumer bus for fifo_sync_flags.
// The master side drives the requests. The slave side is the FIFO, which returns data and status.
interface fifo_sync_flags_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic             clr_err;
  logic [WIDTH-1:0] dout;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, din, rd_en, clr_err,
    input  dout, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en, clr_err,
    output dout, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with registered exact flags, occupancy and sticky error flags.
// Defining FIFO_SYNC_FLAGS_FWFT_EN selects first-word fall-through reads in place of the 1-cycle registered read.
module fifo_sync_flags #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              reset,
  fifo_sync_flags_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q, count_next;
  logic             full_q, empty_q, af_q, ae_q, ovf_q, udf_q;
  logic             rd_acc, wr_acc;

  // Accept decisions use registered flags only. A read frees a slot at full, so a write is also accepted then.
  assign rd_acc     = bus.rd_en & ~empty_q;
  assign wr_acc     = bus.wr_en & (~full_q | bus.rd_en);
  assign count_next = count_q + CW'(wr_acc) - CW'(rd_acc);

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count_q <= count_next;
      full_q  <= (count_next == CW'(DEPTH));
      empty_q <= (count_next == '0);
      af_q    <= (count_next >= CW'(AF_LEVEL));
      ae_q    <= (count_next <= CW'(AE_LEVEL));
      // A new error event in the same cycle as clr_err keeps the flag set.
      ovf_q   <= (bus.wr_en & ~wr_acc) | (ovf_q & ~bus.clr_err);
      udf_q   <= (bus.rd_en & ~rd_acc) | (udf_q & ~bus.clr_err);
    end
  end

`ifdef FIFO_SYNC_FLAGS_FWFT_EN
  assign bus.dout     = mem[rd_ptr];
  assign bus.rd_valid = ~empty_q;
`else
  logic [WIDTH-1:0] dout_q;
  logic             rd_valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) dout_q <= mem[rd_ptr];
    end
  end

  assign bus.dout     = dout_q;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench for fifo_sync_flags with DEPTH=12, AF_LEVEL=10, AE_LEVEL=2.
// It covers both the registered-read and the fall-through build.
module tb_fifo_sync_flags;
  localparam int WIDTH = 8;
  localparam int DEPTH = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  fifo_sync_flags_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  fifo_sync_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(10), .AE_LEVEL(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.clr_err = 1'b0; bus.din = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
    total++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin bad++; $display("FAIL rst_empty_full got=%b%b exp=10", bus.empty, bus.full); end
    total++; if (bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b0) begin bad++; $display("FAIL rst_almost got=%b%b exp=10", bus.almost_empty, bus.almost_full); end
    total++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin bad++; $display("FAIL rst_err got=%b%b exp=00", bus.overflow, bus.underflow); end
`ifndef FIFO_SYNC_FLAGS_FWFT_EN
    total++; if (bus.dout !== 8'h00 || bus.rd_valid !== 1'b0) begin bad++; $display("FAIL rst_dout got=%h/%b exp=00/0", bus.dout, bus.rd_valid); end
`endif
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      bus.wr_en = 1'b1; bus.din = 8'(i);
      tick();
      total++; if (bus.count !== 4'(i)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, bus.count, i); end
      total++; if (bus.full !== (i == DEPTH)) begin bad++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, bus.full, (i == DEPTH)); end
      total++; if (bus.almost_full !== (i >= 10)) begin bad++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, bus.almost_full, (i >= 10)); end
      total++; if (bus.almost_empty !== (i <= 2)) begin bad++; $display("FAIL fill_ae[%0d] got=%b exp=%b", i, bus.almost_empty, (i <= 2)); end
    end
    idle();
  endtask

  task automatic test_overflow();
    bus.wr_en = 1'b1; bus.din = 8'hEE;
    tick();
    idle();
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", bus.overflow); end
    total++; if (bus.count !== 4'd12) begin bad++; $display("FAIL ovf_count got=%0d exp=12", bus.count); end
    tick();
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
    bus.clr_err = 1'b1; bus.wr_en = 1'b1; bus.din = 8'hEE;
    tick();
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b exp=1", bus.overflow); end
    bus.wr_en = 1'b0;
    tick();
    idle();
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", bus.overflow); end
  endtask

  task automatic test_full_rdwr();
    logic [7:0] exp_q [$];
    for (int i = 2; i <= 12; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'hAA);
`ifdef FIFO_SYNC_FLAGS_FWFT_EN
    total++; if (bus.dout !== 8'h01 || bus.rd_valid !== 1'b1) begin bad++; $display("FAIL full_rw_head got=%h/%b exp=01/1", bus.dout, bus.rd_valid); end
`endif
    bus.rd_en = 1'b1; bus.wr_en = 1'b1; bus.din = 8'hAA;
    tick();
    idle();
    total++; if (bus.count !== 4'd12 || bus.full !== 1'b1) begin bad++; $display("FAIL full_rw_count got=%0d/%b exp=12/1", bus.count, bus.full); end
`ifndef FIFO_SYNC_FLAGS_FWFT_EN
    total++; if (bus.dout !== 8'h01 || bus.rd_valid !== 1'b1) begin bad++; $display("FAIL full_rw_dout got=%h/%b exp=01/1", bus.dout, bus.rd_valid); end
`endif
    for (int k = 0; k < 12; k++) begin
`ifdef FIFO_SYNC_FLAGS_FWFT_EN
      total++; if (bus.dout !== exp_q[k] || bus.rd_valid !== 1'b1) begin bad++; $display("FAIL drain[%0d] got=%h/%b exp=%h/1", k, bus.dout, bus.rd_valid, exp_q[k]); end
      bus.rd_en = 1'b1;
      tick();
`else
      bus.rd_en = 1'b1;
      tick();
      total++; if (bus.dout !== exp_q[k] || bus.rd_valid !== 1'b1) begin bad++; $display("FAIL drain[%0d] got=%h/%b exp=%h/1", k, bus.dout, bus.rd_valid, exp_q[k]); end
`endif
    end
    idle();
    total++; if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin bad++; $display("FAIL drain_end got=%0d/%b exp=0/1", bus.count, bus.empty); end
    tick();
`ifndef FIFO_SYNC_FLAGS_FWFT_EN
    total++; if (bus.rd_valid !== 1'b0 || bus.dout !== 8'hAA) begin bad++; $display("FAIL drain_hold got=%h/%b exp=aa/0", bus.dout, bus.rd_valid); end
`endif
  endtask

  task automatic test_empty_rdwr();
    bus.rd_en = 1'b1; bus.wr_en = 1'b1; bus.din = 8'h55;
    tick();
    idle();
    total++; if (bus.underflow !== 1'b1) begin bad++; $display("FAIL empty_rw_udf got=%b exp=1", bus.underflow); end
    total++; if (bus.count !== 4'd1 || bus.empty !== 1'b0) begin bad++; $display("FAIL empty_rw_count got=%0d/%b exp=1/0", bus.count, bus.empty); end
`ifdef FIFO_SYNC_FLAGS_FWFT_EN
    total++; if (bus.rd_valid !== 1'b1 || bus.dout !== 8'h55) begin bad++; $display("FAIL empty_rw_fwft got=%h/%b exp=55/1", bus.dout, bus.rd_valid); end
    bus.rd_en = 1'b1;
    tick();
`else
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL empty_rw_vld got=%b exp=0", bus.rd_valid); end
    bus.rd_en = 1'b1;
    tick();
    total++; if (bus.rd_valid !== 1'b1 || bus.dout !== 8'h55) begin bad++; $display("FAIL empty_rw_read got=%h/%b exp=55/1", bus.dout, bus.rd_valid); end
`endif
    bus.rd_en = 1'b0; bus.clr_err = 1'b1;
    tick();
    idle();
    total++; if (bus.underflow !== 1'b0 || bus.empty !== 1'b1) begin bad++; $display("FAIL udf_clr got=%b/%b exp=0/1", bus.underflow, bus.empty); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      bus.wr_en = 1'b1; bus.din = 8'(8'h10 + i);
      tick();
    end
    idle();
    bus.rd_en = 1'b1;
    tick();
    tick();
    idle();
    total++; if (bus.count !== 4'd3) begin bad++; $display("FAIL mid_pre_count got=%0d exp=3", bus.count); end
    #2 reset = 1'b1;
    #1;
    total++; if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin bad++; $display("FAIL mid_rst got=%0d/%b exp=0/1", bus.count, bus.empty); end
`ifndef FIFO_SYNC_FLAGS_FWFT_EN
    total++; if (bus.dout !== 8'h00 || bus.rd_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_dout got=%h/%b exp=00/0", bus.dout, bus.rd_valid); end
`else
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_vld got=%b exp=0", bus.rd_valid); end
`endif
    tick();
    reset = 1'b0;
    tick();
    bus.wr_en = 1'b1; bus.din = 8'h77;
    tick();
    idle();
`ifdef FIFO_SYNC_FLAGS_FWFT_EN
    total++; if (bus.dout !== 8'h77 || bus.rd_valid !== 1'b1) begin bad++; $display("FAIL mid_after got=%h/%b exp=77/1", bus.dout, bus.rd_valid); end
    bus.rd_en = 1'b1;
    tick();
`else
    bus.rd_en = 1'b1;
    tick();
    total++; if (bus.dout !== 8'h77 || bus.rd_valid !== 1'b1) begin bad++; $display("FAIL mid_after got=%h/%b exp=77/1", bus.dout, bus.rd_valid); end
`endif
    idle();
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL mid_after_empty got=%b exp=1", bus.empty); end
  endtask

`ifdef FIFO_SYNC_FLAGS_FWFT_EN
  task automatic test_fwft();
    bus.wr_en = 1'b1; bus.din = 8'h33;
    tick();
    idle();
    total++; if (bus.rd_valid !== 1'b1 || bus.dout !== 8'h33) begin bad++; $display("FAIL fwft_show got=%h/%b exp=33/1", bus.dout, bus.rd_valid); end
    bus.rd_en = 1'b1;
    tick();
    idle();
    total++; if (bus.rd_valid !== 1'b0 || bus.empty !== 1'b1) begin bad++; $display("FAIL fwft_pop got=%b/%b exp=0/1", bus.rd_valid, bus.empty); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_full_rdwr();
    test_empty_rdwr();
    test_reset_mid();
`ifdef FIFO_SYNC_FLAGS_FWFT_EN
    test_fwft();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
